// File: rtl/sqrt_ctrl_pkg.sv
// rtl/sqrt_ctrl_pkg.sv - shared constants for the square-root core arbiter
package sqrt_ctrl_pkg;

  localparam int FP_W            = 32;
  localparam int DEFAULT_TIMEOUT = 64;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_RESP  = 3'd3;
  localparam logic [2:0] ST_ABORT = 3'd4;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               found
);

  logic [ID_W-1:0] cand;

  // Walk NUM_REQ slots from ptr, wrapping; the first asserted request wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (en && !found && req[cand]) begin
        found       = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sqrt_float_arbiter.sv
// rtl/sqrt_float_arbiter.sv - shares one square_root_float core among NUM_REQ requesters
module sqrt_float_arbiter
  import sqrt_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [FP_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [FP_W-1:0]         rsp_data,
  output logic                    rsp_neg,
  output logic                    rsp_err,
  output logic                    core_start,
  output logic [FP_W-1:0]         core_u,
  input  logic [FP_W-1:0]         core_out,
  input  logic                    core_done,
  input  logic                    core_neg_flag,
  output logic                    core_rst,
  output logic                    busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [2:0]         state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_found;
  logic [CNT_W-1:0]   wd_cnt;
  logic [FP_W-1:0]    req_word [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_word
    assign req_word[i] = req_data[FP_W*i +: FP_W];
  end

  // Gating with rst keeps req_ready low while reset is held.
  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_arb (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .en   ((state == ST_IDLE) && rst),
    .grant(req_ready),
    .idx  (gnt_idx),
    .found(gnt_found)
  );

  assign core_start = (state == ST_ISSUE);
  assign core_rst   = (state != ST_ABORT);
  assign rsp_valid  = (state == ST_RESP);
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      core_u   <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
      rsp_neg  <= 1'b0;
      rsp_err  <= 1'b0;
      wd_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_found) begin
            core_u <= req_word[gnt_idx];
            rsp_id <= gnt_idx;
            rr_ptr <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wd_cnt <= '0;
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done on the last watchdog cycle still wins over the abort.
          if (core_done) begin
            rsp_data <= core_out;
            rsp_neg  <= core_neg_flag;
            rsp_err  <= 1'b0;
            state    <= ST_RESP;
          end else if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
            state <= ST_ABORT;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end
        ST_ABORT: begin
          rsp_data <= '0;
          rsp_neg  <= 1'b0;
          rsp_err  <= 1'b1;
          state    <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_err <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sqrt_float_arbiter.md
Name: sqrt_float_arbiter

Overview:
- Shares one square_root_float core (start/u in, out/done/neg_flag back) among NUM_REQ requesters.
- Round-robin arbitration over valid/ready request channels; one operation in flight at a time.
- Returns result, neg flag and requester id on a single response channel with backpressure.
- Watchdog aborts a hung core and returns an error response.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, 2, requester id width; must equal max(1, clog2(NUM_REQ)).
- TIMEOUT, 64, max cycles spent in WAIT before abort; must exceed core latency.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_data  in  32*NUM_REQ  IEEE-754 single operands; requester i at [32*i+31:32*i]
- req_ready  out  NUM_REQ  one-hot accept; at most one bit high per cycle
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  ID_W  requester index of the response
- rsp_data  out  32  core result (0 on error)
- rsp_neg  out  1  core neg_flag captured with result
- rsp_err  out  1  watchdog abort
- core_start  out  1  one-cycle start pulse to core
- core_u  out  32  operand to core, held stable from ISSUE until return to IDLE
- core_out  in  32  core result
- core_done  in  1  core completion
- core_neg_flag  in  1  core negative-input flag
- core_rst  out  1  active-low reset to core; low for one cycle on abort
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst low, async): state=IDLE; rr_ptr=0; all outputs 0 except core_rst=1; core_u=0.
- States: IDLE, ISSUE, WAIT, RESP, ABORT.
- IDLE:
  - Search req_valid starting at rr_ptr, wrapping modulo NUM_REQ; first set index g wins.
  - req_ready[g]=1 combinationally in the same cycle. Handshake completes that cycle.
  - On handshake: latch core_u<=req_data[g], id<=g, rr_ptr<=(g+1) mod NUM_REQ, go to ISSUE.
  - No valid request: stay in IDLE.
- ISSUE: core_start=1 for exactly this cycle; clear the watchdog counter; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - First cycle with core_done=1: capture core_out and core_neg_flag, go to RESP. A done coincident with counter==TIMEOUT-1 counts as done.
  - Counter reaches TIMEOUT-1 without done: go to ABORT.
- ABORT: core_rst=0 for one cycle; load rsp_data=0, rsp_neg=0, rsp_err=1; go to RESP.
- RESP:
  - rsp_valid=1; rsp_id/rsp_data/rsp_neg/rsp_err held stable until rsp_valid&rsp_ready.
  - On that handshake: go to IDLE, clear rsp_valid and rsp_err.
  - Next grant is no earlier than the following cycle, so minimum issue-to-issue spacing is core latency + 3 cycles.
- req_ready is 0 in every state except IDLE; requesters must hold valid and data until accepted.
- core_done outside WAIT is ignored (no state change, nothing captured).
- Fairness: a continuously asserted requester waits at most NUM_REQ-1 other grants.
- Reset mid-operation returns to IDLE; any in-flight result is discarded and no response is produced.

Decomposition:
- Shared package sqrt_ctrl_pkg: state encoding constants (IDLE, ISSUE, WAIT, RESP, ABORT), FP_W=32, default TIMEOUT.
- Sub-module rr_arbiter (NUM_REQ): inputs req vector, ptr and enable; outputs one-hot grant and encoded index. Purely combinational; the pointer register stays in sqrt_float_arbiter.
- Top-level FSM, operand/result registers and watchdog counter live in sqrt_float_arbiter.

Test Plan:
- Single request: req_valid=0001, data 0x40800000 (4.0); core model with 20-cycle latency.
  -> one core_start pulse; rsp_id=0, rsp_data=0x40000000, rsp_neg=0, rsp_err=0.
- Negative operand: requester 2 sends 0xBF800000; core model sets neg_flag=1.
  -> rsp_id=2, rsp_neg=1.
- All four valid continuously with distinct operands.
  -> grant order 0,1,2,3,0; each rsp_id matches its operand's result; req_ready never has two bits high.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid.
  -> rsp fields stable throughout; no req_ready and no new core_start until the response handshake.
- Hung core: TIMEOUT=64, core never asserts done.
  -> after 64 WAIT cycles core_rst is low for 1 cycle; rsp_err=1, rsp_data=0; next request is then served normally.
- rst low asynchronously during WAIT.
  -> outputs take reset values immediately; no rsp_valid produced; rr_ptr=0 so requester 0 wins next.
